// File: rtl/bitrev_reorder_pkg.sv
// Shared FFT datapath types plus the bit-reversal helper used by the
// reorder buffer and the twiddle-address logic.
package bitrev_reorder_pkg;

  localparam int FFT_DATA_WIDTH = 16;

  typedef struct packed {
    logic signed [FFT_DATA_WIDTH-1:0] data_r;
    logic signed [FFT_DATA_WIDTH-1:0] data_i;
  } FFT_DATA_SAMPLE;

  typedef struct packed {
    logic           valid;
    FFT_DATA_SAMPLE data;
  } FFT_DATA_BUS;

  localparam int SAMPLE_W = $bits(FFT_DATA_SAMPLE);

  // Reverses the low `width` bits of v (width <= 16); upper bits return 0.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int width);
    logic [15:0] r;
    int          j;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < width) begin
        j = width - 1 - k;
        r[k[3:0]] = v[j[3:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_reorder_rev_bank_mem.sv
// One-write/one-read sample array with a registered read port; both
// ping-pong banks live in it, selected by the address MSB.
module rev_bank_mem #(
  parameter int AW = 4,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bitrev_reorder.sv
// Converts a bit-reversed FFT frame to natural order through two
// ping-pong banks, with back-pressure on the output and a bypass path.
module bitrev_reorder
  import bitrev_reorder_pkg::*;
#(
  parameter int SET = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  FFT_DATA_BUS in,
  output logic        in_ready,
  output FFT_DATA_BUS out,
  output logic        out_last,
  input  logic        output_ready,
  input  logic        bypass,
  output logic        overflow
);

  localparam int POINT = 2 ** SET;
  localparam logic [SET-1:0] CNT_MAX = SET'(POINT - 1);

  logic [1:0]     bank_full_q, bank_full_d;
  logic           wb_q, rb_q;
  logic [SET-1:0] wr_cnt_q, rd_cnt_q;
  logic           out_valid_q, out_last_q, overflow_q, byp_q;
  FFT_DATA_SAMPLE byp_data_q;
  FFT_DATA_SAMPLE rdata;

  logic accept, pop, wr_last, rd_last;

  assign in_ready = !bank_full_q[wb_q];
  assign accept   = in.valid && in_ready && !bypass;
  assign pop      = output_ready && bank_full_q[rb_q] && !bypass;
  assign wr_last  = accept && (wr_cnt_q == CNT_MAX);
  assign rd_last  = pop && (rd_cnt_q == CNT_MAX);

  // Write and read completions always hit different banks, so both apply.
  always_comb begin
    bank_full_d = bank_full_q;
    if (wr_last) bank_full_d[wb_q] = 1'b1;
    if (rd_last) bank_full_d[rb_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full_q <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      byp_q       <= 1'b0;
      byp_data_q  <= '0;
    end else begin
      bank_full_q <= bank_full_d;
      if (accept)  wr_cnt_q <= wr_cnt_q + SET'(1);
      if (wr_last) wb_q <= ~wb_q;
      if (pop)     rd_cnt_q <= rd_cnt_q + SET'(1);
      if (rd_last) rb_q <= ~rb_q;
      overflow_q <= overflow_q | (in.valid && !in_ready);
      byp_q      <= bypass;
      if (bypass) begin
        out_valid_q <= in.valid;
        out_last_q  <= 1'b0;
        byp_data_q  <= in.data;
      end else begin
        out_valid_q <= pop;
        out_last_q  <= rd_last;
      end
    end
  end

  rev_bank_mem #(
    .AW (SET + 1),
    .W  (SAMPLE_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i ({wb_q, SET'(bitrev(16'(wr_cnt_q), SET))}),
    .wdata_i (in.data),
    .re_i    (pop),
    .raddr_i ({rb_q, rd_cnt_q}),
    .rdata_o (rdata)
  );

  assign out.valid = out_valid_q;
  assign out.data  = !out_valid_q ? '0 : (byp_q ? byp_data_q : rdata);
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;

  // Mode switches are only meaningful with both banks empty and no partial frame.
  bypass_change_idle: assert property (@(posedge clk) disable iff (rst)
    (bypass != $past(bypass)) |-> (bank_full_q == 2'b00 && wr_cnt_q == '0));

endmodule

// File: tb/tb_bitrev_reorder.sv
// Scoreboard bench for bitrev_reorder at SET=3: stimulus pushes expected
// samples, a negedge monitor pops and compares every valid output.
module tb_bitrev_reorder;
  import bitrev_reorder_pkg::*;

  typedef struct {
    FFT_DATA_SAMPLE data;
    logic           last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  FFT_DATA_BUS in_bus;
  logic        in_ready;
  FFT_DATA_BUS out_bus;
  logic        out_last;
  logic        output_ready;
  logic        bypass;
  logic        overflow;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   rev3[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  bitrev_reorder #(.SET(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in_bus),
    .in_ready     (in_ready),
    .out          (out_bus),
    .out_last     (out_last),
    .output_ready (output_ready),
    .bypass       (bypass),
    .overflow     (overflow)
  );

  function automatic FFT_DATA_SAMPLE mk(input logic [15:0] r);
    FFT_DATA_SAMPLE s;
    s.data_r = r;
    s.data_i = r ^ 16'hA500;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic send_sample(input logic [15:0] r);
    in_bus.valid = 1'b1;
    in_bus.data  = mk(r);
    @(posedge clk);
    #1;
    in_bus.valid = 1'b0;
    in_bus.data  = '0;
  endtask

  task automatic send_frame(input int base, input bit push, input bit chk_ready);
    exp_t e;
    for (int j = 0; j < 8; j++) begin
      if (chk_ready) check("in_ready_during_frame", 32'(in_ready), 32'd1);
      send_sample(16'(base + j));
    end
    if (push) begin
      for (int n = 0; n < 8; n++) begin
        e.data = mk(16'(base + rev3[n]));
        e.last = (n == 7);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every valid output must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_bus.valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output: got r=%0h i=%0h last=%b, required no output",
                   out_bus.data.data_r, out_bus.data.data_i, out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_bus.data !== e.data || out_last !== e.last) begin
            miscompares++;
            $display("FAIL out_sample: got r=%0h i=%0h last=%b, required r=%0h i=%0h last=%b",
                     out_bus.data.data_r, out_bus.data.data_i, out_last,
                     e.data.data_r, e.data.data_i, e.last);
          end else begin
            $display("out  r=%0h i=%0h last=%b", out_bus.data.data_r, out_bus.data.data_i, out_last);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit seen;
    exp_t e;

    rst = 1'b1;
    in_bus = '0;
    output_ready = 1'b0;
    bypass = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_bus.valid), 32'd0);
    check("rst_out_data", 32'(out_bus.data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single frame, reorder and first-output latency.
    output_ready = 1'b1;
    send_frame(0, 1'b1, 1'b0);
    cyc = 1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (out_bus.valid) seen = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    check("first_valid_latency", 32'(cyc), 32'd2);
    drain();

    // Back-to-back frames stream gap-free.
    fork
      begin
        send_frame(0, 1'b1, 1'b1);
        send_frame(8, 1'b1, 1'b1);
      end
      begin
        int k, run;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!out_bus.valid && k < 100);
        run = out_bus.valid ? 1 : 0;
        repeat (15) begin
          @(negedge clk);
          if (out_bus.valid) run++;
        end
        check("contiguous_outputs", 32'(run), 32'd16);
      end
    join
    drain();

    // Both banks full: third frame dropped, overflow sticky.
    output_ready = 1'b0;
    send_frame(0, 1'b1, 1'b0);
    send_frame(8, 1'b1, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("pre_overflow", 32'(overflow), 32'd0);
    send_frame(16, 1'b0, 1'b0);
    check("overflow_set", 32'(overflow), 32'd1);
    check("stall_no_output", 32'(out_bus.valid), 32'd0);
    output_ready = 1'b1;
    drain();
    check("in_ready_after_drain", 32'(in_ready), 32'd1);

    // Back-pressure toggling during readout.
    output_ready = 1'b0;
    send_frame(0, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) begin
      output_ready = (i % 2 == 0);
      @(posedge clk);
      #1;
    end
    output_ready = 1'b1;
    drain();

    // Reset mid-frame discards the partial frame.
    send_sample(16'd40);
    send_sample(16'd41);
    send_sample(16'd42);
    send_sample(16'd43);
    send_sample(16'd44);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_bus.valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(0, 1'b1, 1'b0);
    drain();

    // Bypass: one-register pass-through, no last flag.
    bypass = 1'b1;
    @(posedge clk);
    #1;
    check("bypass_in_ready", 32'(in_ready), 32'd1);
    e.data = mk(16'h11); e.last = 1'b0; exp_q.push_back(e);
    e.data = mk(16'h22); e.last = 1'b0; exp_q.push_back(e);
    send_sample(16'h11);
    check("bypass_latency_valid", 32'(out_bus.valid), 32'd1);
    send_sample(16'h22);
    drain();
    bypass = 1'b0;
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
